// File: rtl/rtc_sync_ctrl_if.sv
// Handshake bundle between the RTC sync controller, its user-side time setter
// and the DS1302 serial driver. All time words are 56-bit BCD.
interface rtc_sync_ctrl_if;
    logic        set_req;
    logic [55:0] set_time;
    logic        set_ack;
    logic        drv_write_req;
    logic        drv_write_ack;
    logic [55:0] drv_write_time;
    logic        drv_read_req;
    logic        drv_read_ack;
    logic [55:0] drv_read_time;
    logic [55:0] time_out;
    logic        time_valid;
    logic        err_timeout;
    logic        err_bcd;

    modport master (
        input  set_req, set_time, drv_write_ack, drv_read_ack, drv_read_time,
        output set_ack, drv_write_req, drv_write_time, drv_read_req,
               time_out, time_valid, err_timeout, err_bcd
    );

    modport slave (
        output set_req, set_time, drv_write_ack, drv_read_ack, drv_read_time,
        input  set_ack, drv_write_req, drv_write_time, drv_read_req,
               time_out, time_valid, err_timeout, err_bcd
    );
endinterface

// File: rtl/rtc_sync_ctrl.sv
// Keeps a validated copy of the DS1302 time: initial read, auto-init on clock
// halt (CH), periodic polling, user time writes and per-request timeouts.
module rtc_sync_ctrl #(
    parameter int unsigned POLL_CYCLES    = 5_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [55:0] DEFAULT_TIME   = 56'h16_02_12_13_19_15_01,
    parameter bit          AUTO_INIT      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    rtc_sync_ctrl_if.master io_bus
);

    localparam int unsigned PW = $clog2(POLL_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [55:0]   INIT_WORD = {DEFAULT_TIME[55:8], 1'b0, DEFAULT_TIME[6:0]};

    typedef enum logic [2:0] {
        S_INIT_RD,
        S_INIT_WR,
        S_IDLE,
        S_POLL_RD,
        S_SET_WR
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rd_req;
    logic          r_wr_req;
    logic          w_rd_req_nxt;
    logic          w_wr_req_nxt;
    logic [TW-1:0] r_to_cnt;
    logic [PW-1:0] r_poll_cnt;
    logic [55:0]   r_set_time;
    logic [55:0]   r_wr_time;
    logic          r_pending;
    logic          r_set_again;
    logic          r_set_ack;
    logic [55:0]   r_time_out;
    logic          r_time_valid;
    logic          r_err_timeout;
    logic          r_err_bcd;

    logic w_is_rd;
    logic w_is_wr;
    logic w_rd_done;
    logic w_wr_done;
    logic w_ack;
    logic w_req_any;
    logic w_timeout;
    logic w_poll_done;
    logic w_wr_load;
    logic w_ch;
    logic w_rd_ok;

    // Range check of a BCD time word; the CH bit is masked off before checking.
    function automatic logic time_ok(input logic [55:0] t);
        logic [55:0] m;
        logic        ok;
        m  = {t[55:8], 1'b0, t[6:0]};
        ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (m[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (m[7:0]   > 8'h59)                       ok = 1'b0;
        if (m[15:8]  > 8'h59)                       ok = 1'b0;
        if (m[23:16] > 8'h23)                       ok = 1'b0;
        if (m[31:24] == 8'h00 || m[31:24] > 8'h31)  ok = 1'b0;
        if (m[39:32] == 8'h00 || m[39:32] > 8'h12)  ok = 1'b0;
        if (m[47:40] == 8'h00 || m[47:40] > 8'h07)  ok = 1'b0;
        return ok;
    endfunction

    // Acks only count while the matching request is actually raised.
    assign w_is_rd     = (r_state == S_INIT_RD) || (r_state == S_POLL_RD);
    assign w_is_wr     = (r_state == S_INIT_WR) || (r_state == S_SET_WR);
    assign w_rd_done   = r_rd_req && io_bus.drv_read_ack;
    assign w_wr_done   = r_wr_req && io_bus.drv_write_ack;
    assign w_ack       = w_rd_done || w_wr_done;
    assign w_req_any   = r_rd_req || r_wr_req;
    assign w_timeout   = w_req_any && !w_ack && (r_to_cnt == TO_LAST);
    assign w_poll_done = (r_poll_cnt == POLL_LAST);
    assign w_wr_load   = w_is_wr && !r_wr_req;
    assign w_ch        = io_bus.drv_read_time[7];
    assign w_rd_ok     = time_ok(io_bus.drv_read_time);

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_req_nxt = 1'b0;
        w_wr_req_nxt = 1'b0;
        case (r_state)
            S_INIT_RD, S_POLL_RD: begin
                w_rd_req_nxt = !w_rd_done && !w_timeout;
                if (w_timeout)      w_state_nxt = S_IDLE;
                else if (w_rd_done) w_state_nxt = (w_ch && AUTO_INIT) ? S_INIT_WR : S_IDLE;
            end
            S_INIT_WR, S_SET_WR: begin
                w_wr_req_nxt = !w_wr_done && !w_timeout;
                if (w_timeout)      w_state_nxt = S_IDLE;
                else if (w_wr_done) w_state_nxt = S_POLL_RD;
            end
            S_IDLE: begin
                if (r_pending)        w_state_nxt = S_SET_WR;
                else if (w_poll_done) w_state_nxt = S_POLL_RD;
            end
            default: w_state_nxt = S_INIT_RD;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_INIT_RD;
            r_rd_req      <= 1'b0;
            r_wr_req      <= 1'b0;
            r_to_cnt      <= '0;
            r_poll_cnt    <= '0;
            r_wr_time     <= '0;
            r_pending     <= 1'b0;
            r_set_again   <= 1'b0;
            r_set_ack     <= 1'b0;
            r_time_out    <= '0;
            r_time_valid  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_bcd     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_req   <= w_rd_req_nxt;
            r_wr_req   <= w_wr_req_nxt;
            r_to_cnt   <= (w_req_any && !w_ack && !w_timeout) ? r_to_cnt + TW'(1) : '0;
            // IDLE lasts exactly POLL_CYCLES cycles; the count restarts on every entry.
            r_poll_cnt <= (r_state == S_IDLE && w_state_nxt == S_IDLE) ? r_poll_cnt + PW'(1) : '0;
            r_set_ack  <= (r_state == S_SET_WR) && w_wr_done;

            if (w_wr_load) begin
                r_wr_time <= (r_state == S_SET_WR)
                           ? {r_set_time[55:8], 1'b0, r_set_time[6:0]} : INIT_WORD;
            end

            // A set arriving after the write word was captured keeps the request pending.
            if (io_bus.set_req)                     r_set_again <= 1'b1;
            else if (w_wr_load && r_state == S_SET_WR) r_set_again <= 1'b0;

            if (io_bus.set_req)                     r_pending <= 1'b1;
            else if (r_state == S_SET_WR && w_wr_done) r_pending <= r_set_again;

            if (w_timeout)  r_err_timeout <= 1'b1;
            else if (w_ack) r_err_timeout <= 1'b0;

            if (w_rd_done) begin
                if (w_ch) begin
                    r_time_valid <= 1'b0;
                end else if (w_rd_ok) begin
                    r_time_out   <= io_bus.drv_read_time;
                    r_time_valid <= 1'b1;
                    r_err_bcd    <= 1'b0;
                end else begin
                    r_err_bcd    <= 1'b1;
                end
            end
        end
    end

    // NOTE: r_set_time is pure data, only read after a set_req has loaded it, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (io_bus.set_req) r_set_time <= io_bus.set_time;
    end

    assign io_bus.drv_read_req   = r_rd_req;
    assign io_bus.drv_write_req  = r_wr_req;
    assign io_bus.drv_write_time = r_wr_time;
    assign io_bus.set_ack        = r_set_ack;
    assign io_bus.time_out       = r_time_out;
    assign io_bus.time_valid     = r_time_valid;
    assign io_bus.err_timeout    = r_err_timeout;
    assign io_bus.err_bcd        = r_err_bcd;

endmodule

// File: tb/tb_rtc_sync_ctrl.sv
// Directed bench for rtc_sync_ctrl: emulates the DS1302 driver handshake and
// checks init, polling, range checking, user sets, timeout and reset behaviour.
module tb_rtc_sync_ctrl;

    localparam int POLL = 16;
    localparam int TOUT = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rtc_sync_ctrl_if rtc_if ();

    rtc_sync_ctrl #(
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TOUT),
        .DEFAULT_TIME   (56'h16_02_12_13_19_15_01),
        .AUTO_INIT      (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (rtc_if)
    );

    always #5 clk = ~clk;

    int n_checks    = 0;
    int n_errors    = 0;
    int set_ack_cnt = 0;

    always @(negedge clk) if (rtc_if.set_ack === 1'b1) set_ack_cnt++;

    typedef struct {
        logic [55:0] rd;
        logic [55:0] exp_out;
        logic        exp_valid;
        logic        exp_bcd;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns the number of edges until the request is seen high, or -1.
    task automatic wait_req(input bit is_wr, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk); #1;
            n++;
            if (is_wr ? rtc_if.drv_write_req : rtc_if.drv_read_req) return;
        end
        n = -1;
    endtask

    task automatic ack_read(input logic [55:0] t);
        rtc_if.drv_read_time = t;
        rtc_if.drv_read_ack  = 1'b1;
        @(posedge clk); #1;
        rtc_if.drv_read_ack  = 1'b0;
        rtc_if.drv_read_time = '0;
    endtask

    task automatic ack_write();
        rtc_if.drv_write_ack = 1'b1;
        @(posedge clk); #1;
        rtc_if.drv_write_ack = 1'b0;
    endtask

    task automatic pulse_set(input logic [55:0] t);
        rtc_if.set_req  = 1'b1;
        rtc_if.set_time = t;
        @(posedge clk); #1;
        rtc_if.set_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int hi;
        int base;

        rtc_if.set_req       = 1'b0;
        rtc_if.set_time      = '0;
        rtc_if.drv_write_ack = 1'b0;
        rtc_if.drv_read_ack  = 1'b0;
        rtc_if.drv_read_time = '0;

        // {read word, expected time_out, expected time_valid, expected err_bcd}
        vecs[0]  = '{56'h24_03_05_17_23_59_58, 56'h24_03_05_17_23_59_58, 1'b1, 1'b0};
        vecs[1]  = '{56'h24_03_05_17_23_60_58, 56'h24_03_05_17_23_59_58, 1'b1, 1'b1};
        vecs[2]  = '{56'h99_07_12_31_23_59_59, 56'h99_07_12_31_23_59_59, 1'b1, 1'b0};
        vecs[3]  = '{56'h99_07_12_31_24_00_00, 56'h99_07_12_31_23_59_59, 1'b1, 1'b1};
        vecs[4]  = '{56'h00_01_01_01_00_00_00, 56'h00_01_01_01_00_00_00, 1'b1, 1'b0};
        vecs[5]  = '{56'h00_01_01_00_00_00_00, 56'h00_01_01_01_00_00_00, 1'b1, 1'b1};
        vecs[6]  = '{56'h00_00_01_01_00_00_00, 56'h00_01_01_01_00_00_00, 1'b1, 1'b1};
        vecs[7]  = '{56'h00_08_01_01_00_00_00, 56'h00_01_01_01_00_00_00, 1'b1, 1'b1};
        vecs[8]  = '{56'h00_01_13_01_00_00_00, 56'h00_01_01_01_00_00_00, 1'b1, 1'b1};
        vecs[9]  = '{56'h00_01_01_32_00_00_00, 56'h00_01_01_01_00_00_00, 1'b1, 1'b1};
        vecs[10] = '{56'h00_01_01_01_00_00_60, 56'h00_01_01_01_00_00_00, 1'b1, 1'b1};
        vecs[11] = '{56'h2A_01_01_01_00_00_00, 56'h00_01_01_01_00_00_00, 1'b1, 1'b1};
        vecs[12] = '{56'h00_01_00_01_00_00_00, 56'h00_01_01_01_00_00_00, 1'b1, 1'b1};
        vecs[13] = '{56'h45_06_09_28_12_34_56, 56'h45_06_09_28_12_34_56, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_reqs", {61'd0, rtc_if.drv_read_req, rtc_if.drv_write_req, rtc_if.set_ack}, 64'd0);
        check("reset_time_out", {8'd0, rtc_if.time_out}, 64'd0);
        check("reset_write_time", {8'd0, rtc_if.drv_write_time}, 64'd0);
        check("reset_flags", {61'd0, rtc_if.time_valid, rtc_if.err_timeout, rtc_if.err_bcd}, 64'd0);
        rst = 1'b0;

        // Halted clock found at init: default time written, then read back
        wait_req(1'b0, 8, n);
        check("init_rd_latency", 64'(n), 64'd1);
        ack_read(56'h24_03_05_17_23_59_81);
        check("rd_req_low_after_ack", {63'd0, rtc_if.drv_read_req}, 64'd0);
        wait_req(1'b1, 8, n);
        check("init_wr_latency", 64'(n), 64'd1);
        check("init_wr_time", {8'd0, rtc_if.drv_write_time}, {8'd0, 56'h16_02_12_13_19_15_01});
        check("init_wr_no_read_req", {63'd0, rtc_if.drv_read_req}, 64'd0);
        ack_write();
        check("wr_req_low_after_ack", {63'd0, rtc_if.drv_write_req}, 64'd0);
        wait_req(1'b0, 8, n);
        check("readback_latency", 64'(n), 64'd1);
        ack_read(56'h16_02_12_13_19_15_01);
        check("readback_time_out", {8'd0, rtc_if.time_out}, {8'd0, 56'h16_02_12_13_19_15_01});
        check("readback_valid", {63'd0, rtc_if.time_valid}, 64'd1);

        // Polled reads through the range checker; IDLE is POLL cycles, request one edge later
        for (int i = 0; i < 14; i++) begin
            wait_req(1'b0, POLL + 8, n);
            check($sformatf("poll_interval[%0d]", i), 64'(n), 64'(POLL + 1));
            ack_read(vecs[i].rd);
            check($sformatf("time_out[%0d]", i), {8'd0, rtc_if.time_out}, {8'd0, vecs[i].exp_out});
            check($sformatf("time_valid[%0d]", i), {63'd0, rtc_if.time_valid}, {63'd0, vecs[i].exp_valid});
            check($sformatf("err_bcd[%0d]", i), {63'd0, rtc_if.err_bcd}, {63'd0, vecs[i].exp_bcd});
        end

        // Stray acks in IDLE are ignored; they take one of the POLL idle cycles
        rtc_if.drv_read_time = 56'h24_03_05_17_23_60_58;
        rtc_if.drv_read_ack  = 1'b1;
        rtc_if.drv_write_ack = 1'b1;
        @(posedge clk); #1;
        rtc_if.drv_read_ack  = 1'b0;
        rtc_if.drv_write_ack = 1'b0;
        rtc_if.drv_read_time = '0;
        check("stray_ack_time_out", {8'd0, rtc_if.time_out}, {8'd0, 56'h45_06_09_28_12_34_56});
        check("stray_ack_err_bcd", {63'd0, rtc_if.err_bcd}, 64'd0);
        wait_req(1'b0, POLL + 8, n);
        check("poll_interval_after_stray", 64'(n), 64'(POLL));

        // Two sets during POLL_RD: latest wins, CH bit cleared, one set_ack
        base = set_ack_cnt;
        pulse_set(56'h11_02_03_04_05_06_07);
        pulse_set(56'h25_01_01_01_00_00_80);
        ack_read(56'h45_06_09_28_12_34_57);
        check("poll_before_set_time_out", {8'd0, rtc_if.time_out}, {8'd0, 56'h45_06_09_28_12_34_57});
        wait_req(1'b1, 8, n);
        check("set_wr_latency", 64'(n), 64'd2);
        check("set_wr_time", {8'd0, rtc_if.drv_write_time}, {8'd0, 56'h25_01_01_01_00_00_00});
        repeat (3) @(posedge clk);
        #1;
        check("set_wr_held", {7'd0, rtc_if.drv_write_req, rtc_if.drv_write_time},
              {7'd0, 1'b1, 56'h25_01_01_01_00_00_00});
        ack_write();
        check("set_ack_pulse", {63'd0, rtc_if.set_ack}, 64'd1);
        wait_req(1'b0, 8, n);
        check("set_readback_latency", 64'(n), 64'd1);
        ack_read(56'h25_01_01_01_00_00_00);
        check("set_readback_time_out", {8'd0, rtc_if.time_out}, {8'd0, 56'h25_01_01_01_00_00_00});
        check("set_ack_count", 64'(set_ack_cnt - base), 64'd1);

        // Unanswered read: request high exactly TOUT cycles, sticky error until next ack
        wait_req(1'b0, POLL + 8, n);
        check("poll_interval_after_set", 64'(n), 64'(POLL + 1));
        hi = 1;
        while (hi <= TOUT + 5) begin
            @(posedge clk); #1;
            if (rtc_if.drv_read_req) hi++;
            else break;
        end
        check("timeout_req_cycles", 64'(hi), 64'(TOUT));
        check("timeout_err_set", {63'd0, rtc_if.err_timeout}, 64'd1);
        wait_req(1'b0, POLL + 8, n);
        check("poll_interval_after_timeout", 64'(n), 64'(POLL + 1));
        check("timeout_err_sticky", {63'd0, rtc_if.err_timeout}, 64'd1);
        ack_read(56'h45_06_09_28_12_34_56);
        check("timeout_err_cleared", {63'd0, rtc_if.err_timeout}, 64'd0);

        // Reset in the middle of SET_WR
        base = set_ack_cnt;
        pulse_set(56'h30_04_06_15_10_20_30);
        wait_req(1'b1, 8, n);
        check("rst_case_set_wr_latency", 64'(n), 64'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_drops_reqs", {62'd0, rtc_if.drv_read_req, rtc_if.drv_write_req}, 64'd0);
        @(posedge clk); #1;
        check("rst_clears_outputs",
              {5'd0, rtc_if.time_out, rtc_if.time_valid, rtc_if.err_timeout, rtc_if.err_bcd}, 64'd0);
        rst = 1'b0;
        wait_req(1'b0, 8, n);
        check("rst_restart_init_rd", 64'(n), 64'd1);
        check("rst_restart_no_write", {63'd0, rtc_if.drv_write_req}, 64'd0);
        ack_read(56'h45_06_09_28_12_34_56);
        wait_req(1'b0, POLL + 8, n);
        check("rst_dropped_pending_set", 64'(n), 64'(POLL + 1));
        check("rst_no_set_ack", 64'(set_ack_cnt - base), 64'd0);
        ack_read(56'h45_06_09_28_12_34_59);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rtc_sync_ctrl.md
RTC_SYNC_CTRL -- requirements
Module: rtc_sync_ctrl

Interface
REQ-001 Parameter POLL_CYCLES, default 5_000_000, clk cycles from end of one poll/set transaction to start of next poll read.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000, max clk cycles a driver request may wait for its ack.
REQ-003 Parameter DEFAULT_TIME, default 56'h16_02_12_13_19_15_01, init time written when CH found set.
REQ-004 Parameter AUTO_INIT, default 1, 1 = write DEFAULT_TIME when CH=1; 0 = report only.
REQ-005 Time word layout, all 56-bit buses: [55:48] year, [47:40] week, [39:32] month, [31:24] date, [23:16] hour, [15:8] minute, [7:0] second; BCD; second[7] = CH.
REQ-006 clk  in  1  system clock, single clock domain.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 set_req  in  1  one-cycle pulse requesting a user time write.
REQ-009 set_time  in  56  user time, sampled on the set_req cycle.
REQ-010 set_ack  out  1  one-cycle pulse when the user write completes.
REQ-011 drv_write_req  out  1  write request to the DS1302 serial driver.
REQ-012 drv_write_ack  in  1  driver one-cycle write-done pulse.
REQ-013 drv_write_time  out  56  time presented to driver, stable while drv_write_req=1.
REQ-014 drv_read_req  out  1  read request to driver.
REQ-015 drv_read_ack  in  1  driver one-cycle read-done pulse; drv_read_time valid that cycle.
REQ-016 drv_read_time  in  56  time read by driver.
REQ-017 time_out  out  56  last valid time, second[7] forced 0.
REQ-018 time_valid  out  1  time_out holds a validated reading.
REQ-019 err_timeout  out  1  sticky: a driver request timed out.
REQ-020 err_bcd  out  1  sticky: last read failed range check.

Function
REQ-021 States SHALL be INIT_RD, INIT_WR, IDLE, POLL_RD, SET_WR, exactly one drv_*_req asserted in RD/WR states, none in IDLE.
REQ-022 Request SHALL assert the cycle after state entry, hold until ack sampled, and be low on the cycle after ack; transition on ack cycle.
REQ-023 INIT_RD on ack: CH=1 and AUTO_INIT=1 -> INIT_WR; else -> IDLE.
REQ-024 INIT_WR SHALL drive DEFAULT_TIME with bit7 cleared; on ack -> POLL_RD (read-back).
REQ-025 IDLE SHALL count POLL_CYCLES then -> POLL_RD; pending set SHALL pre-empt the count and go -> SET_WR next cycle.
REQ-026 set_req in any state SHALL latch set_time and a pending flag; a second set_req before service overwrites the latched time (one set_ack only).
REQ-027 SET_WR SHALL drive latched time with bit7 cleared; on ack: set_ack pulse next cycle, pending cleared, -> POLL_RD.
REQ-028 POLL_RD on ack: valid and CH=0 -> time_out updated, time_valid=1, err_bcd=0; invalid -> err_bcd=1, time_out/time_valid unchanged; CH=1 -> time_valid=0, -> INIT_WR if AUTO_INIT else IDLE.
REQ-029 Range check: sec/min 00-59, hour 00-23 (24h), date 01-31, month 01-12, week 1-7, year 00-99, every nibble <= 9.
REQ-030 Timeout counter SHALL run while any request is high; reaching TIMEOUT_CYCLES drops request, sets err_timeout, -> IDLE (poll counter restarts; pending set kept).
REQ-031 err_timeout SHALL clear on the next successful ack.
REQ-032 Set-time while pending during INIT_RD/INIT_WR SHALL wait until IDLE.
REQ-033 Ack received in a state not expecting it SHALL be ignored.

Reset
REQ-034 rst=1 SHALL force state INIT_RD, all outputs 0, counters 0, pending set cleared, no set_ack issued for a dropped set.
REQ-035 rst mid-transaction SHALL deassert driver requests on the next clk edge.

Verification
REQ-036 Read ack with second=8'h81, AUTO_INIT=1 -> INIT_WR writes 56'h16_02_12_13_19_15_01, then read-back.
REQ-037 Read 56'h24_03_05_17_23_59_58 -> time_out equal, time_valid=1, next poll exactly POLL_CYCLES after.
REQ-038 set_req with 56'h25_01_01_01_00_00_00 during POLL_RD -> SET_WR after read ack, one set_ack, read-back.
REQ-039 Read minute=8'h60 -> err_bcd=1, time_out unchanged.
REQ-040 No ack for TIMEOUT_CYCLES -> request low, err_timeout=1; next good ack clears it.
REQ-041 rst during SET_WR -> requests low next edge, no set_ack, restart at INIT_RD.
